// File: rtl/counter_delayed_trigger_multi_if.sv
// Bundle between the period sequencer side and the delayed trigger block.
// Ports (slave view): counter_reset, reference_counter, presamples, mode,
//   arm, trigger_reset in; trigger, armed_status, last_counter,
//   last_valid, overflow out. Master is the mirror image.
interface counter_delayed_trigger_multi_if #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4
);
   logic                      counter_reset;
   logic [WIDTH-1:0]          reference_counter;
   logic [CHANNELS*WIDTH-1:0] presamples;
   logic [CHANNELS-1:0]       mode;
   logic [CHANNELS-1:0]       arm;
   logic [CHANNELS-1:0]       trigger_reset;
   logic [CHANNELS-1:0]       trigger;
   logic [CHANNELS-1:0]       armed_status;
   logic [WIDTH-1:0]          last_counter;
   logic                      last_valid;
   logic                      overflow;

   modport master (
      output counter_reset, reference_counter, presamples,
      output mode, arm, trigger_reset,
      input  trigger, armed_status, last_counter,
      input  last_valid, overflow
   );

   modport slave (
      input  counter_reset, reference_counter, presamples,
      input  mode, arm, trigger_reset,
      output trigger, armed_status, last_counter,
      output last_valid, overflow
   );
endinterface

// File: rtl/counter_delayed_trigger_multi.sv
// Multi-channel delayed trigger: measures the counter_reset period with a
// saturating counter and fires each channel presamples[c] cycles early.
// Ports: clk, areset (async, active high), bus (slave modport, see _if).
module counter_delayed_trigger_multi #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4
) (
   input  logic clk,
   input  logic areset,
   counter_delayed_trigger_multi_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_FIRED
   } state_t;

   localparam logic [WIDTH-1:0] MAXV = '1;
   localparam logic [WIDTH-1:0] ONE  = 1;

   logic [WIDTH-1:0]    r_cnt;
   logic [WIDTH-1:0]    r_last;
   logic                r_valid;
   logic                r_ovf;
   logic                r_cr_prev;
   logic [WIDTH-1:0]    w_cnt_nxt;
   logic [WIDTH-1:0]    w_base;
   logic                w_cap;
   logic [CHANNELS-1:0] w_trig;
   logic [CHANNELS-1:0] w_armed;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (bus.counter_reset)
         w_cnt_nxt = '0;
      else if (r_cnt != MAXV)
         w_cnt_nxt = r_cnt + ONE;
   end

   // cr_prev resets high so leaving reset never looks like a rising edge.
   assign w_cap  = bus.counter_reset & ~r_cr_prev;
   assign w_base = r_valid ? r_last : bus.reference_counter;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_cnt     <= '0;
         r_last    <= '0;
         r_valid   <= 1'b0;
         r_ovf     <= 1'b0;
         r_cr_prev <= 1'b1;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_cr_prev <= bus.counter_reset;
         if (w_cap) begin
            r_last  <= r_cnt;
            r_valid <= 1'b1;
         end
         if (bus.counter_reset)
            r_ovf <= 1'b0;
         else if (w_cnt_nxt == MAXV)
            r_ovf <= 1'b1;
      end
   end

   genvar g;
   generate
      for (g = 0; g < CHANNELS; g++) begin : g_ch
         logic [WIDTH-1:0] w_pre;
         logic [WIDTH-1:0] w_tgt;
         logic             w_match;
         state_t           r_st;
         logic             r_trig;
         logic             r_armed;
         logic             r_done;

         assign w_pre   = bus.presamples[g*WIDTH +: WIDTH];
         assign w_tgt   = (w_base > w_pre) ? (w_base - w_pre) : '0;
         assign w_match = (r_cnt == w_tgt) & ~bus.counter_reset;

         // r_done stops a saturated counter (parked on the target) from
         // pulsing every cycle; one pulse per period.
         always_ff @(posedge clk or posedge areset) begin
            if (areset) begin
               r_st    <= S_IDLE;
               r_trig  <= 1'b0;
               r_armed <= 1'b0;
               r_done  <= 1'b0;
            end else begin
               if (bus.counter_reset)
                  r_done <= 1'b0;
               if (bus.trigger_reset[g]) begin
                  r_st    <= S_IDLE;
                  r_trig  <= 1'b0;
                  r_armed <= 1'b0;
               end else begin
                  unique case (r_st)
                     S_IDLE: begin
                        r_trig <= 1'b0;
                        if (bus.arm[g]) begin
                           r_st    <= S_ARMED;
                           r_armed <= 1'b1;
                        end
                     end
                     S_ARMED: begin
                        r_trig <= 1'b0;
                        if (w_match & ~r_done) begin
                           r_trig <= 1'b1;
                           if (bus.mode[g]) begin
                              r_done <= 1'b1;
                           end else begin
                              r_st    <= S_FIRED;
                              r_armed <= 1'b0;
                           end
                        end
                     end
                     S_FIRED: begin
                        r_trig <= 1'b1;
                     end
                     default: begin
                        r_st    <= S_IDLE;
                        r_trig  <= 1'b0;
                        r_armed <= 1'b0;
                     end
                  endcase
               end
            end
         end

         assign w_trig[g]  = r_trig;
         assign w_armed[g] = r_armed;
      end
   endgenerate

   assign bus.trigger      = w_trig;
   assign bus.armed_status = w_armed;
   assign bus.last_counter = r_last;
   assign bus.last_valid   = r_valid;
   assign bus.overflow     = r_ovf;

endmodule

// File: doc/counter_delayed_trigger_multi.md
# counter_delayed_trigger_multi

Parametrised, multi-channel successor to the single-channel delayed trigger. It measures the period between `counter_reset` rising edges with a shared saturating cycle counter. Each channel fires a trigger `presamples` cycles before the predicted end of the next period, in either latched or per-period pulse mode. It sits between the acquisition-period sequencer and the per-channel ADC/DAC trigger inputs.

## Interface
- `WIDTH`, 32: width of counter, reference, presample and capture values.
- `CHANNELS`, 4: number of independent trigger channels.

- `clk` in 1: sole clock; all logic on rising edge.
- `areset` in 1: asynchronous, active-high reset.
- `counter_reset` in 1: period marker, level, synchronous to `clk`; counter held at 0 while high.
- `reference_counter` in WIDTH: fallback period length used until the first capture.
- `presamples` in CHANNELS*WIDTH: per-channel lead, channel c at bits [c*WIDTH +: WIDTH].
- `mode` in CHANNELS: per channel, 0 = latched, 1 = pulse.
- `arm` in CHANNELS: per-channel arm request, sampled each cycle.
- `trigger_reset` in CHANNELS: per-channel disarm/clear, sampled each cycle.
- `trigger` out CHANNELS: registered trigger outputs.
- `armed_status` out CHANNELS: high while the channel is in ARMED.
- `last_counter` out WIDTH: period length captured at the last `counter_reset` rising edge.
- `last_valid` out 1: high once at least one capture has happened.
- `overflow` out 1: counter reached all-ones in the current period.

## Operation
- Counter:
  - next value = 0 if `counter_reset`; else hold if all-ones; else +1.
  - Saturates, never wraps.
  - `overflow` is set when the counter reaches all-ones and cleared when `counter_reset` is high.
- Edge detect:
  - `cr_prev` register resets to 1, so reset never produces a capture.
  - Capture condition is `counter_reset & ~cr_prev`.
  - On capture: `last_counter` <= current counter, `last_valid` <= 1. The captured value equals the number of cycles `counter_reset` was low.
- Base:
  - base = `last_counter` if `last_valid`, else `reference_counter`.
  - Per-channel target = base − presamples[c], saturating at 0 (no underflow wrap).
- Match:
  - match[c] = (counter == target[c]) & ~`counter_reset`.
- Per-channel FSM, states IDLE, ARMED, FIRED:
  - `trigger_reset[c]` forces IDLE from any state. It has priority over `arm` and match in the same cycle.
  - IDLE: `arm[c]` -> ARMED.
  - ARMED + match, `mode`=0: -> FIRED.
  - ARMED + match, `mode`=1: stays ARMED; `trigger[c]` pulses for one cycle.
  - FIRED: `trigger[c]` held high until `trigger_reset[c]`. `arm` is ignored.
  - `arm` while ARMED or FIRED: no effect.
- `mode` is sampled at the match cycle. Changing `mode` while FIRED has no effect until the channel returns to IDLE.
- Channels are fully independent. All share the counter and `last_counter`.

## Timing
- Reset values: counter 0, `last_counter` 0, `last_valid` 0, `overflow` 0, all FSMs IDLE, `trigger` 0, `armed_status` 0.
- `areset` mid-operation: immediate return to reset values; triggers drop asynchronously.
- Arm latency: `armed_status` is high in the cycle after `arm` is sampled.
- Trigger latency: `trigger` is high in the cycle after match, i.e. while counter == target+1.
  - Exception: at saturation, counter holds at target and no second pulse is generated. Match is level-qualified by the FSM state, so in pulse mode it fires once per period: the match→pulse path is gated by a per-channel "fired this period" flag, cleared by `counter_reset`.
- Capture: `last_counter` and `last_valid` update in the cycle after the rising edge of `counter_reset`. The new base applies to the match in the following period.
- If target exceeds the reachable period, no trigger fires in that period. The channel stays ARMED.
- If target = 0, the channel fires on the first cycle after `counter_reset` falls, when counter = 0.
- Counter with WIDTH bits saturates at 2^WIDTH−1. `last_counter` then captures 2^WIDTH−1.

## Test plan
- Reset: hold `areset`=1 while toggling `arm` and `counter_reset` -> all outputs 0. After release, no capture until the first genuine `counter_reset` rising edge.
- Capture: `counter_reset` low for 400 cycles between pulses -> `last_counter`=400 and `last_valid`=1 one cycle after the second rising edge.
- Latched fallback: `reference_counter`=250, presamples[0]=50, `mode`[0]=0, arm before any capture -> `trigger`[0] rises when counter=201 and stays high across later periods. `trigger_reset`[0] -> 0 next cycle, `armed_status`[0]=0.
- Pulse mode: `last_counter`=400, presamples[1]=100, `mode`[1]=1 -> exactly one 1-cycle pulse per period at counter=301, `armed_status`[1] stays 1, over 3 periods.
- Boundaries:
  - presamples[2]=500 with base 400 -> fires on the first cycle after `counter_reset` falls.
  - `arm`[3] and `trigger_reset`[3] asserted in the same cycle -> IDLE.
- Overflow: WIDTH=8, `counter_reset` low for 300 cycles -> counter holds 255, `overflow`=1, `last_counter`=255, `overflow` cleared during the next `counter_reset`.
